lab00_debounce: RTL

//  Conditions a raw asynchronous push-button/switch into a clean, glitch-free level plus one-cycle

---
 rtl/lab00_debounce_pkg.sv | 22 ++
 rtl/lab00_sync2.sv | 24 ++
 rtl/lab00_debounce.sv | 126 ++++++++++++
 3 files changed

// File: rtl/lab00_debounce_pkg.sv
// Shared definitions for the lab00 debouncer: FSM state encodings, reset values
// and the sample-counter width helper.
package lab00_debounce_pkg;

   typedef enum logic [1:0] {
      ST_LOW     = 2'd0,
      ST_TO_HIGH = 2'd1,
      ST_HIGH    = 2'd2,
      ST_TO_LOW  = 2'd3
   } state_t;

   localparam state_t RST_STATE = ST_LOW;
   localparam logic   RST_SYNC  = 1'b0;
   localparam logic   RST_LEVEL = 1'b0;
   localparam logic   RST_PULSE = 1'b0;

   // A one-sample filter still needs a 1-bit counter so the vector is never zero-width.
   function automatic int cnt_width(input int stable_cycles);
      return (stable_cycles > 1) ? $clog2(stable_cycles) : 1;
   endfunction

endpackage

// File: rtl/lab00_sync2.sv
// Two-flop synchronizer for bringing an asynchronous signal into the i_clk domain.
module lab00_sync2 #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         meta <= RST_VAL;
         o_q  <= RST_VAL;
      end else begin
         meta <= i_d;
         o_q  <= meta;
      end
   end

endmodule

// File: rtl/lab00_debounce.sv
// Debounces a raw button into a clean level, one-cycle rise/fall pulses and a
// wrapping press counter. o_state exposes the FSM state for observation.
module lab00_debounce
   import lab00_debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_btn,
   output logic             o_level,
   output logic             o_rise,
   output logic             o_fall,
   output logic [CNT_W-1:0] o_presses,
   output logic [1:0]       o_state
);

   localparam int          CW   = cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

   logic             s;
   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic             accept_rise;
   logic             accept_fall;
   logic             level_nxt;
   logic [CNT_W-1:0] presses_nxt;

   lab00_sync2 #(
      .WIDTH   (1),
      .RST_VAL (RST_SYNC)
   ) u_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_btn),
      .o_q   (s)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= RST_STATE;
         cnt       <= '0;
         o_level   <= RST_LEVEL;
         o_rise    <= RST_PULSE;
         o_fall    <= RST_PULSE;
         o_presses <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         o_level   <= level_nxt;
         o_rise    <= accept_rise;
         o_fall    <= accept_fall;
         o_presses <= presses_nxt;
      end
   end

   // cnt counts consecutive samples that disagree with the current level.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      accept_rise = 1'b0;
      accept_fall = 1'b0;
      case (state)
         ST_LOW: begin
            if (s) begin
               if (STABLE_CYCLES == 1) begin
                  accept_rise = 1'b1;
               end else begin
                  state_nxt = ST_TO_HIGH;
                  cnt_nxt   = CW'(1);
               end
            end
         end
         ST_TO_HIGH: begin
            if (!s) begin
               state_nxt = ST_LOW;
               cnt_nxt   = '0;
            end else if (cnt == LAST) begin
               accept_rise = 1'b1;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         ST_HIGH: begin
            if (!s) begin
               if (STABLE_CYCLES == 1) begin
                  accept_fall = 1'b1;
               end else begin
                  state_nxt = ST_TO_LOW;
                  cnt_nxt   = CW'(1);
               end
            end
         end
         ST_TO_LOW: begin
            if (s) begin
               state_nxt = ST_HIGH;
               cnt_nxt   = '0;
            end else if (cnt == LAST) begin
               accept_fall = 1'b1;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = ST_LOW;
            cnt_nxt   = '0;
         end
      endcase
      if (accept_rise) begin
         state_nxt = ST_HIGH;
         cnt_nxt   = '0;
      end
      if (accept_fall) begin
         state_nxt = ST_LOW;
         cnt_nxt   = '0;
      end
      level_nxt   = (state_nxt == ST_HIGH) || (state_nxt == ST_TO_LOW);
      presses_nxt = accept_rise ? o_presses + CNT_W'(1) : o_presses;
   end

   assign o_state = state;

endmodule
